qpmux_sel_ctrl: RTL and testbench

//  Sequencer that drives the select pins (IS0/IS1) of the QPMUX global clock mux.
//  - Arbitrates source-switch requests from NUM_REQ requesters (round-robin).
//  - Gates the downstream clock (GATE_EN low) for the whole switch, then changes the select.
//  - Waits for a settle window before ungating, so no runt pulse reaches the clock tree.
//  - Runs on one housekeeping clock, independent of the muxed clocks.

---
 rtl/qpmux_sel_pkg.sv | 23 ++
 rtl/qpmux_rr_arb.sv | 22 ++
 rtl/qpmux_sel_ctrl.sv | 155 +++++++++++++++
 tb/tb_qpmux_sel_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/qpmux_sel_pkg.sv
// qpmux_sel_pkg: shared states, source codes and source-equivalence helper for the QPMUX select sequencer.
package qpmux_sel_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GRANT,
        S_GATE_OFF,
        S_SETTLE,
        S_FINISH
    } state_t;

    localparam logic [1:0] SRC_QCLKIN = 2'b00;
    localparam logic [1:0] SRC_GMUXIN = 2'b01;
    localparam logic [1:0] SRC_QHSCK  = 2'b10;
    localparam logic [1:0] SRC_RSVD   = 2'b11;

    // Codes 10 and 11 both select QHSCK on the mux.
    function automatic logic src_equiv(input logic [1:0] a, input logic [1:0] b);
        return (a == b) || (a[1] && b[1]);
    endfunction

endpackage

// File: rtl/qpmux_rr_arb.sv
// qpmux_rr_arb: combinational round-robin winner select, highest priority at the pointer.
module qpmux_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic               any,
    output logic [PW-1:0]      win
);

    assign any = |valid;

    // Scan from the farthest slot back to the pointer so the nearest valid requester wins.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % NUM_REQ]) win = PW'((int'(ptr) + k) % NUM_REQ);
        end
    end

endmodule

// File: rtl/qpmux_sel_ctrl.sv
// qpmux_sel_ctrl: gated, settle-timed select sequencer for the QPMUX clock mux.
// Optional QPMUX_SEL_ERR_EN adds the err port and rejects the reserved code 2'b11.
module qpmux_sel_ctrl
    import qpmux_sel_pkg::*;
#(
    parameter int         NUM_REQ       = 2,
    parameter int         GATE_CYCLES   = 4,
    parameter int         SETTLE_CYCLES = 8,
    parameter logic [1:0] RESET_SRC     = 2'b00
) (
    input  logic                 qck,
    input  logic                 qrt,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_src,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   done,
    output logic                 is0,
    output logic                 is1,
    output logic                 gate_en,
    output logic                 busy,
`ifdef QPMUX_SEL_ERR_EN
    output logic                 err,
`endif
    output logic [1:0]           cur_src
);

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] GLAST = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] SLAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PLAST = PW'(NUM_REQ - 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [1:0]           cur, cur_n, lat, lat_n, sel;
    logic [PW-1:0]        own, own_n, ptr, ptr_n, win;
    logic [NUM_REQ-1:0]   ready_n, done_n;
    logic                 gate_n, busy_n, any, rsvd;
`ifdef QPMUX_SEL_ERR_EN
    logic                 err_n;
`endif

    qpmux_rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .any   (any),
        .win   (win)
    );

    assign sel = req_src[2*int'(win) +: 2];
`ifdef QPMUX_SEL_ERR_EN
    assign rsvd = (sel == SRC_RSVD);
`else
    assign rsvd = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        lat_n   = lat;
        own_n   = own;
        ptr_n   = ptr;
        gate_n  = gate_en;
        ready_n = '0;
        done_n  = '0;
`ifdef QPMUX_SEL_ERR_EN
        err_n   = 1'b0;
`endif
        case (state)
            S_INIT: begin
                cnt_n   = (cnt == SLAST) ? '0 : cnt + 1'b1;
                gate_n  = (cnt == SLAST);
                state_n = (cnt == SLAST) ? S_IDLE : S_INIT;
            end
            S_IDLE: begin
                if (any) begin
                    ready_n[win] = 1'b1;
                    lat_n        = sel;
                    own_n        = win;
                    ptr_n        = (win == PLAST) ? '0 : win + 1'b1;
                    // Same-source and rejected requests complete without touching the gate.
                    if (rsvd) state_n = S_FINISH;
                    else if (src_equiv(sel, cur)) state_n = S_GRANT;
                    else begin
                        state_n = S_GATE_OFF;
                        gate_n  = 1'b0;
                    end
                end
            end
            S_GRANT: begin
                done_n[own] = 1'b1;
                state_n     = S_IDLE;
            end
            S_FINISH: begin
                done_n[own] = 1'b1;
`ifdef QPMUX_SEL_ERR_EN
                err_n       = 1'b1;
`endif
                state_n     = S_IDLE;
            end
            S_GATE_OFF: begin
                cnt_n   = (cnt == GLAST) ? '0 : cnt + 1'b1;
                cur_n   = (cnt == GLAST) ? lat : cur;
                state_n = (cnt == GLAST) ? S_SETTLE : S_GATE_OFF;
            end
            S_SETTLE: begin
                cnt_n       = (cnt == SLAST) ? '0 : cnt + 1'b1;
                gate_n      = (cnt == SLAST);
                done_n[own] = (cnt == SLAST);
                state_n     = (cnt == SLAST) ? S_IDLE : S_SETTLE;
            end
            default: state_n = S_INIT;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge qck or posedge qrt) begin
        if (qrt) begin
            state     <= S_INIT;
            cnt       <= '0;
            cur       <= RESET_SRC;
            lat       <= RESET_SRC;
            own       <= '0;
            ptr       <= '0;
            gate_en   <= 1'b0;
            busy      <= 1'b1;
            req_ready <= '0;
            done      <= '0;
`ifdef QPMUX_SEL_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur       <= cur_n;
            lat       <= lat_n;
            own       <= own_n;
            ptr       <= ptr_n;
            gate_en   <= gate_n;
            busy      <= busy_n;
            req_ready <= ready_n;
            done      <= done_n;
`ifdef QPMUX_SEL_ERR_EN
            err       <= err_n;
`endif
        end
    end

    assign is0     = cur[0];
    assign is1     = cur[1];
    assign cur_src = cur;

endmodule

// File: tb/tb_qpmux_sel_ctrl.sv
// tb_qpmux_sel_ctrl: randomized and directed checks of the QPMUX select sequencer against a timing model.
module tb_qpmux_sel_ctrl;

    localparam int N = 2;
    localparam int G = 4;
    localparam int S = 8;
    localparam logic [1:0] RST_SRC = 2'b00;

    logic           qck = 1'b0;
    logic           qrt = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_src = '0;
    logic [N-1:0]   req_ready, done;
    logic           is0, is1, gate_en, busy;
    logic [1:0]     cur_src;
`ifdef QPMUX_SEL_ERR_EN
    logic           err;
`endif

    int vectors = 0;
    int miscompares = 0;
    int         mp = 0;
    logic [1:0] mcur = RST_SRC;

    qpmux_sel_ctrl #(.NUM_REQ(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .RESET_SRC(RST_SRC)) dut (
        .qck       (qck),
        .qrt       (qrt),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_ready (req_ready),
        .done      (done),
        .is0       (is0),
        .is1       (is1),
        .gate_en   (gate_en),
        .busy      (busy),
`ifdef QPMUX_SEL_ERR_EN
        .err       (err),
`endif
        .cur_src   (cur_src)
    );

    always #5 qck = ~qck;

    // Serves the request currently presented; expected timing derived from the rotating-priority rule.
    task automatic do_req(input string nm);
        int w, d;
        logic same, rsv, eg, eb, ee, ae;
        logic [1:0] ns, old, ec;
        logic [N-1:0] er, ed;
        w = -1;
        for (int j = 0; j < N; j++) if (w < 0 && req_valid[(mp + j) % N]) w = (mp + j) % N;
        ns = req_src[2*w +: 2];
        old = mcur;
`ifdef QPMUX_SEL_ERR_EN
        rsv = (ns == 2'b11);
`else
        rsv = 1'b0;
`endif
        same = rsv || ns == old || (ns >= 2 && old >= 2);
        d = same ? 2 : 1 + G + S;
        mp = (w + 1) % N;
        if (!same) mcur = ns;
        @(posedge qck);
        for (int k = 1; k <= d; k++) begin
            @(negedge qck);
            er = '0; ed = '0;
            if (k == 1) er[w] = 1'b1;
            if (k == d) ed[w] = 1'b1;
            eg = same ? 1'b1 : (k == d);
            ec = (!same && k >= 1 + G) ? ns : old;
            eb = (k < d);
            ee = rsv && (k == d);
`ifdef QPMUX_SEL_ERR_EN
            ae = err;
`else
            ae = ee;
`endif
            vectors++;
            if ({req_ready, done, gate_en, is1, is0, busy, ae} !== {er, ed, eg, ec, eb, ee}) begin
                miscompares++;
                $display("FAIL %s cyc T+%0d: got rdy=%b done=%b gate=%b is=%b%b busy=%b err=%b, want rdy=%b done=%b gate=%b is=%b busy=%b err=%b",
                         nm, k, req_ready, done, gate_en, is1, is0, busy, ae, er, ed, eg, ec, eb, ee);
            end
            if (k == 1) req_valid[w] = 1'b0;
        end
    endtask

    task automatic test_reset();
        qrt = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge qck);
        vectors++;
        if ({gate_en, busy, cur_src, req_ready, done} !== {1'b0, 1'b1, RST_SRC, {N{1'b0}}, {N{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_hold: got gate=%b busy=%b cur=%b rdy=%b done=%b", gate_en, busy, cur_src, req_ready, done);
        end
        qrt = 1'b0;
        mp = 0;
        mcur = RST_SRC;
        for (int k = 1; k <= S; k++) begin
            @(negedge qck);
            vectors++;
            if ({gate_en, busy, cur_src, done} !== {k == S, k < S, RST_SRC, {N{1'b0}}}) begin
                miscompares++;
                $display("FAIL init cyc %0d: got gate=%b busy=%b cur=%b done=%b, want gate=%b busy=%b", k, gate_en, busy, cur_src, done, k == S, k < S);
            end
        end
    endtask

    task automatic test_switch();
        req_src = 4'b00_01;
        req_valid = 2'b01;
        do_req("switch_00_01");
    endtask

    task automatic test_same_source();
        req_src = 4'b10_01;
        req_valid = 2'b10;
        do_req("to_qhsck");
        req_src = 4'b10_11;
        req_valid = 2'b01;
        do_req("same_10_11");
    endtask

    task automatic test_reset_mid();
        test_reset();
        req_src = 4'b00_10;
        req_valid = 2'b01;
        @(posedge qck);
        for (int k = 1; k <= 1 + G + 3; k++) begin
            @(negedge qck);
            req_valid = '0;
        end
        #2 qrt = 1'b1;
        #1;
        vectors++;
        if ({cur_src, gate_en, busy, done} !== {RST_SRC, 1'b0, 1'b1, {N{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_mid: got cur=%b gate=%b busy=%b done=%b", cur_src, gate_en, busy, done);
        end
        test_reset();
    endtask

    task automatic test_back_to_back();
        req_src = 4'b10_01;
        req_valid = 2'b11;
        do_req("rr_first");
        do_req("rr_second");
        req_src = 4'b01_00;
        req_valid = 2'b11;
        do_req("rr_third");
        do_req("rr_fourth");
    endtask

    task automatic test_rsvd();
        req_src = 4'b00_01;
        req_valid = 2'b01;
        do_req("pre_rsvd");
        req_src = 4'b00_11;
        req_valid = 2'b01;
        do_req("rsvd_11");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            req_src = 4'($urandom);
            req_valid = 2'($urandom_range(1, 3));
            do_req("random");
            if (req_valid != '0) do_req("random_b2b");
            repeat ($urandom_range(0, 2)) @(negedge qck);
        end
    endtask

    initial begin
        @(negedge qck);
        test_reset();
        test_switch();
        test_same_source();
        test_reset_mid();
        test_back_to_back();
        test_rsvd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
